// File: rtl/uart_rx_lsu_slave.sv
// UART receiver peripheral on the LSU port: 2-flop rx synchroniser, 8N1
// deserialiser, byte FIFO, RXDATA/STATUS/CTRL registers with a fixed
// one-cycle response, and a level interrupt while data is pending.
// Optional 8E1 framing with a parity check: define UART_RX_PARITY_EN.
module uart_rx_lsu_slave #(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_serial,
    input  logic        lsu_sel,
    input  logic        lsu_rd,
    input  logic        lsu_wr,
    input  logic [3:0]  lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_ready,
    output logic        irq
);

    localparam int unsigned BCW   = $clog2(BAUD_DIV);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [BCW-1:0] FULL_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_meta, rx_sync, rx_prev;
    logic             rx_fall;
    logic             push_req, frame_set, parity_set;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overrun, frame_err, parity_err, irq_en;

    logic             rd_en, wr_en, ctrl_wr, clr, flush;
    logic             not_empty, full, push, pop, overrun_set;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^lsu_wdata[31:3];

    // Synchronise rx and keep the previous synchronised value for edge detect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    // Receiver state register, baud counter, bit index and shift register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    // Receiver next-state logic: mid-bit sampling and frame outcome strobes
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + BCW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push_req   = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                if (rx_fall) state_d = S_START;
            end
            S_START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    if (!rx_sync) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (baud_cnt_q == FULL_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_sync, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_cnt_q == FULL_LAST) begin
                    baud_cnt_d = '0;
                    par_bad_d  = ^{shift_q, rx_sync};
                    parity_set = par_bad_d;
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_cnt_q == FULL_LAST) begin
                    baud_cnt_d = '0;
                    state_d    = S_IDLE;
                    if (rx_sync) begin
`ifdef UART_RX_PARITY_EN
                        push_req = ~par_bad_q;
`else
                        push_req = 1'b1;
`endif
                    end else begin
                        frame_set = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_en       = lsu_sel & lsu_rd;
    assign wr_en       = lsu_sel & lsu_wr;
    assign ctrl_wr     = wr_en & (lsu_addr == 4'h8);
    assign clr         = ctrl_wr & lsu_wdata[1];
    assign flush       = ctrl_wr & lsu_wdata[2];
    assign not_empty   = (count_q != '0);
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop         = rd_en & (lsu_addr == 4'h0) & not_empty;
    // Full is judged on the pre-pop count, so push+pop on a full FIFO overruns
    assign push        = push_req & ~full;
    assign overrun_set = push_req & full;

    // FIFO storage write
    always_ff @(posedge clock) begin
        if (push) mem[wptr_q] <= shift_q;
    end

    // FIFO pointers and occupancy; a flush overrides any push or pop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun    <= overrun_set | (overrun    & ~clr);
            frame_err  <= frame_set   | (frame_err  & ~clr);
            parity_err <= parity_set  | (parity_err & ~clr);
        end
    end

    // Stored CTRL bit: interrupt enable
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       irq_en <= 1'b0;
        else if (ctrl_wr) irq_en <= lsu_wdata[0];
    end

    // Load data selection from pre-update state
    always_comb begin
        rd_mux = '0;
        if (rd_en) begin
            case (lsu_addr)
                4'h0: if (not_empty) rd_mux = {24'h0, mem[rptr_q]};
                4'h4: rd_mux = {22'h0, 6'(count_q), parity_err, frame_err, overrun, not_empty};
                default: rd_mux = '0;
            endcase
        end
    end

    // Registered LSU response and interrupt
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lsu_rdata <= '0;
            lsu_ready <= 1'b0;
            irq       <= 1'b0;
        end else begin
            lsu_rdata <= rd_mux;
            lsu_ready <= rd_en | wr_en;
            irq       <= irq_en & not_empty;
        end
    end

endmodule

// File: doc/uart_rx_lsu_slave.md
Name: uart_rx_lsu_slave

Overview:
- Memory-mapped UART receiver peripheral that acts as the responder to the pipeline LSU's load/store requests.
- Deserialises 8N1 frames from the rx pin and buffers received bytes in a small FIFO.
- Exposes data, status and control registers to the LSU with a fixed 1-cycle response.
- Sits on the LSU peripheral port alongside the UART transmitter; raises an interrupt while data is pending.

Parameters:
- BAUD_DIV, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 8, receive FIFO entries; power of two.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_serial  input  1  asynchronous serial line; idle high.
- lsu_sel  input  1  LSU selects this peripheral this cycle.
- lsu_rd  input  1  load request, qualified by lsu_sel.
- lsu_wr  input  1  store request, qualified by lsu_sel.
- lsu_addr  input  4  byte address: 0x0 RXDATA, 0x4 STATUS, 0x8 CTRL.
- lsu_wdata  input  32  store data.
- lsu_rdata  output  32  load data; valid when lsu_ready=1.
- lsu_ready  output  1  one-cycle pulse completing any selected access.
- irq  output  1  high while FIFO non-empty and CTRL.irq_en=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - lsu_rdata=0, lsu_ready=0, irq=0.
  - FIFO empty; pointers and count at 0.
  - Sticky flags cleared; CTRL=0.
  - FSM in IDLE; both rx synchroniser flops set to 1.
  - Reset asserted mid-frame discards the partial byte. After release, the FSM waits for a fresh falling edge.
- Input sync: rx_serial passes through a 2-flop synchroniser. Edge detection uses the synchronised value and its previous copy.
- FSM states and transitions:
  - IDLE: on a synchronised falling edge, clear the baud counter and go to START.
  - START: count BAUD_DIV/2 cycles, then sample. Low -> go to DATA with bit index 0. High -> glitch; return to IDLE, nothing recorded.
  - DATA: sample every BAUD_DIV cycles (mid-bit), shifting LSB first. After bit 7, go to STOP.
  - STOP: sample after BAUD_DIV cycles, then return to IDLE.
    - Sample = 1: push the byte. If the FIFO is full, drop the byte and set overrun.
    - Sample = 0: set frame_err and discard the byte.
  - A held-low line after STOP does not retrigger; a new falling edge is required.
- Push and pop:
  - The push happens in the cycle of the stop-bit sample.
  - Simultaneous push and pop in one cycle: both occur and the count is unchanged. The popped entry is the oldest.
  - The push-when-full check uses the count before that cycle's pop. Push and pop together on a full FIFO is therefore an overrun.
- LSU protocol:
  - A request is valid when lsu_sel & (lsu_rd | lsu_wr).
  - lsu_ready pulses high the next cycle for every request, including unmapped addresses. There is no wait state and no back-pressure.
  - lsu_rdata is registered and returns to 0 on the cycle after the ready pulse.
- Read registers:
  - RXDATA read: returns {24'b0, oldest byte} and pops. On an empty FIFO it returns 0 with no state change.
  - STATUS read: {22'b0, count[5:0], parity_err, frame_err, overrun, not_empty}. count is zero-extended to 6 bits. No side effects.
  - Reads of unmapped addresses return 0.
- Write registers:
  - CTRL write: bit0 = irq_en (stored). Bit1 = 1 clears overrun, frame_err and parity_err, and is self-clearing. Bit2 = 1 flushes the FIFO.
  - A flush coinciding with a push leaves the FIFO empty (flush wins).
  - Writes to RXDATA, STATUS or unmapped addresses are ignored but still acknowledged.
- Sticky flags: set by the receiver and held until cleared by CTRL bit1. If a set and a clear happen in the same cycle, the set wins.
- irq is registered and updates one cycle after a change in FIFO state.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - The frame is 8E1; a PARITY state sits between DATA and STOP and samples the bit after bit 7.
  - If the XOR of the data bits and the parity bit is 1, set parity_err and do not push the byte. The stop bit is still checked.
- When undefined: there is no PARITY state and parity_err (STATUS bit3) reads 0.

Test Plan:
- Single byte: BAUD_DIV=16, send 0xA5 8N1. STATUS reads count=1, not_empty=1. RXDATA read returns 0x000000A5, with lsu_ready exactly 1 cycle after the request. Follow-up STATUS reads 0.
- Overrun: FIFO_DEPTH=8, send 9 bytes 0x01..0x09 with no reads. Overrun=1, count=8. Eight RXDATA reads return 0x01..0x08, then the FIFO is empty.
- Framing and glitch:
  - Frame 0x3C with the stop bit driven 0 -> frame_err=1, count=0.
  - A 3-cycle low glitch on idle rx -> no state change.
  - A CTRL write of 0x2 clears frame_err.
- Concurrency and flush:
  - With count=3, issue an RXDATA read on the same cycle as a stop-bit push -> count stays 3, the oldest byte is returned.
  - A CTRL write of 0x4 -> count=0.
- Reset and irq:
  - Assert reset during the DATA bits of 0xFF. After release, STATUS=0 and irq=0.
  - Write CTRL=0x1, then receive 0x55 -> irq rises 1 cycle after the push and drops 1 cycle after the pop.
- Parity (macro defined): send 0x07 with parity bit 0 -> parity_err=1, count=0. Send 0x07 with parity bit 1 -> count=1, data 0x07.
